// File: rtl/imem_loader.sv
// Packs decoded RV32I fields into instruction words and streams them into IMEM at consecutive word addresses.
// Latency: one cycle from beat acceptance to the IMEM write strobe; back-to-back beats give one write per cycle.
// Backpressure: o_ready is high for the whole LOAD state and low otherwise; unencodable beats are accepted and dropped.
module imem_loader #(
  parameter int ADDR_W = 16,
  parameter int FMT_W  = 3
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_base_addr,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic              i_last,
  input  logic [FMT_W-1:0]  i_fmt,
  input  logic [6:0]        i_opcode,
  input  logic [2:0]        i_funct3,
  input  logic [6:0]        i_funct7,
  input  logic [4:0]        i_rd,
  input  logic [4:0]        i_rs1,
  input  logic [4:0]        i_rs2,
  input  logic [31:0]       i_imm,
  output logic              o_imem_we,
  output logic [ADDR_W-1:0] o_imem_addr,
  output logic [31:0]       o_imem_wdata,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err,
  output logic [ADDR_W-1:0] o_count
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] wr_ptr;
  logic [31:0]       enc_word;
  logic              enc_ok;
  logic signed [31:0] imm_s;
  logic              unused_base_lsbs;

  assign imm_s = i_imm;
  // Word alignment is forced, so the two lowest base bits never matter.
  assign unused_base_lsbs = ^i_base_addr[1:0];

  // Encode the current beat and decide whether its immediate fits the chosen format.
  always_comb begin
    enc_word = '0;
    enc_ok   = 1'b0;
    case (i_fmt)
      FMT_W'(0): begin
        enc_word = {i_funct7, i_rs2, i_rs1, i_funct3, i_rd, i_opcode};
        enc_ok   = 1'b1;
      end
      FMT_W'(1): begin
        enc_word = {i_imm[11:0], i_rs1, i_funct3, i_rd, i_opcode};
        enc_ok   = (imm_s >= -2048) && (imm_s <= 2047);
      end
      FMT_W'(2): begin
        enc_word = {i_imm[11:5], i_rs2, i_rs1, i_funct3, i_imm[4:0], i_opcode};
        enc_ok   = (imm_s >= -2048) && (imm_s <= 2047);
      end
      FMT_W'(3): begin
        enc_word = {i_imm[12], i_imm[10:5], i_rs2, i_rs1, i_funct3,
                    i_imm[4:1], i_imm[11], i_opcode};
        enc_ok   = (imm_s >= -4096) && (imm_s <= 4095) && !i_imm[0];
      end
      FMT_W'(4): begin
        enc_word = {i_imm[31:12], i_rd, i_opcode};
        enc_ok   = (i_imm[11:0] == 12'd0);
      end
      FMT_W'(5): begin
        enc_word = {i_imm[20], i_imm[10:1], i_imm[11], i_imm[19:12], i_rd, i_opcode};
        enc_ok   = (imm_s >= -1048576) && (imm_s <= 1048575) && !i_imm[0];
      end
      default: begin
        enc_word = '0;
        enc_ok   = 1'b0;
      end
    endcase
  end

  // Session FSM: registers the encoded write, advances pointer/count, and drives all status outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state        <= ST_IDLE;
      wr_ptr       <= '0;
      o_ready      <= 1'b0;
      o_imem_we    <= 1'b0;
      o_imem_addr  <= '0;
      o_imem_wdata <= '0;
      o_busy       <= 1'b0;
      o_done       <= 1'b0;
      o_err        <= 1'b0;
      o_count      <= '0;
    end else begin
      o_imem_we <= 1'b0;
      o_done    <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (i_start) begin
            state   <= ST_LOAD;
            wr_ptr  <= {i_base_addr[ADDR_W-1:2], 2'b00};
            o_count <= '0;
            o_err   <= 1'b0;
            o_ready <= 1'b1;
            o_busy  <= 1'b1;
          end
        end
        ST_LOAD: begin
          if (i_valid && o_ready) begin
            if (enc_ok) begin
              o_imem_we    <= 1'b1;
              o_imem_addr  <= wr_ptr;
              o_imem_wdata <= enc_word;
              wr_ptr       <= wr_ptr + ADDR_W'(4);
              o_count      <= o_count + ADDR_W'(1);
            end else begin
              o_err <= 1'b1;
            end
            // The last beat's write lands in the DONE cycle, alongside o_done.
            if (i_last) begin
              state   <= ST_DONE;
              o_ready <= 1'b0;
              o_done  <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          state  <= ST_IDLE;
          o_busy <= 1'b0;
        end
        default: begin
          state   <= ST_IDLE;
          o_ready <= 1'b0;
          o_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
